// File: rtl/gcm_ctr_scheduler.sv
// gcm_ctr_scheduler
// Sequences one AES core through a single AES-GCM encryption job. It requests
// H = E(K,0), then E(K,J0), then one counter-mode keystream block per
// plaintext block. Each keystream block is XORed with the plaintext and
// streamed out. Only one ciphertext block is ever in flight.
module gcm_ctr_scheduler #(
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [95:0]          i_iv,
  input  logic [BLK_CNT_W-1:0] i_num_blks,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_aes_en,
  output logic [127:0]         o_aes_block,
  input  logic                 i_aes_ready,
  input  logic                 i_aes_valid,
  input  logic [127:0]         i_aes_block,
  input  logic                 i_pt_valid,
  output logic                 o_pt_ready,
  input  logic [127:0]         i_pt_data,
  output logic                 o_ct_valid,
  input  logic                 i_ct_ready,
  output logic [127:0]         o_ct_data,
  output logic [127:0]         o_h,
  output logic                 o_h_valid,
  output logic [127:0]         o_ekj0,
  output logic                 o_ekj0_valid
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_H_REQ    = 4'd1;
  localparam logic [3:0] S_H_WAIT   = 4'd2;
  localparam logic [3:0] S_J0_REQ   = 4'd3;
  localparam logic [3:0] S_J0_WAIT  = 4'd4;
  localparam logic [3:0] S_CTR_REQ  = 4'd5;
  localparam logic [3:0] S_CTR_WAIT = 4'd6;
  localparam logic [3:0] S_XOR      = 4'd7;
  localparam logic [3:0] S_OUT      = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;

  logic [3:0]           state;
  logic [95:0]          iv;
  logic [BLK_CNT_W-1:0] num_blks;
  logic [BLK_CNT_W-1:0] blk_cnt;
  logic [31:0]          ctr_lo;
  logic [127:0]         ks;

  // GCM inc32: only the low word counts, and it wraps modulo 2^32.
  function automatic logic [31:0] inc32(input logic [31:0] v);
    return v + 32'd1;
  endfunction

  // Control strobes are plain decodes of the current state.
  assign o_busy     = (state != S_IDLE);
  assign o_done     = (state == S_DONE);
  assign o_pt_ready = (state == S_XOR);
  assign o_aes_en   = i_aes_ready &&
                      ((state == S_H_REQ) || (state == S_J0_REQ) || (state == S_CTR_REQ));

  // AES input block: driven in each request state and held through its wait state.
  always_comb begin
    o_aes_block = 128'd0;
    case (state)
      S_H_REQ, S_H_WAIT:     o_aes_block = 128'd0;
      S_J0_REQ, S_J0_WAIT:   o_aes_block = {iv, 32'h0000_0001};
      S_CTR_REQ, S_CTR_WAIT: o_aes_block = {iv, ctr_lo};
      default:               o_aes_block = 128'd0;
    endcase
  end

  // Job FSM together with its latched job parameters and registered data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      iv           <= 96'd0;
      num_blks     <= {BLK_CNT_W{1'b0}};
      blk_cnt      <= {BLK_CNT_W{1'b0}};
      ctr_lo       <= 32'd0;
      ks           <= 128'd0;
      o_h          <= 128'd0;
      o_h_valid    <= 1'b0;
      o_ekj0       <= 128'd0;
      o_ekj0_valid <= 1'b0;
      o_ct_data    <= 128'd0;
      o_ct_valid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            iv           <= i_iv;
            num_blks     <= i_num_blks;
            ctr_lo       <= 32'h0000_0002;
            blk_cnt      <= {BLK_CNT_W{1'b0}};
            o_h_valid    <= 1'b0;
            o_ekj0_valid <= 1'b0;
            state        <= S_H_REQ;
          end
        end
        S_H_REQ: begin
          if (i_aes_ready) state <= S_H_WAIT;
        end
        S_H_WAIT: begin
          if (i_aes_valid) begin
            o_h       <= i_aes_block;
            o_h_valid <= 1'b1;
            state     <= S_J0_REQ;
          end
        end
        S_J0_REQ: begin
          if (i_aes_ready) state <= S_J0_WAIT;
        end
        S_J0_WAIT: begin
          if (i_aes_valid) begin
            o_ekj0       <= i_aes_block;
            o_ekj0_valid <= 1'b1;
            // An empty message needs no keystream at all.
            if (num_blks != {BLK_CNT_W{1'b0}}) state <= S_CTR_REQ;
            else                               state <= S_DONE;
          end
        end
        S_CTR_REQ: begin
          if (i_aes_ready) state <= S_CTR_WAIT;
        end
        S_CTR_WAIT: begin
          if (i_aes_valid) begin
            ks    <= i_aes_block;
            state <= S_XOR;
          end
        end
        S_XOR: begin
          if (i_pt_valid) begin
            o_ct_data  <= i_pt_data ^ ks;
            o_ct_valid <= 1'b1;
            blk_cnt    <= blk_cnt + BLK_CNT_W'(1);
            state      <= S_OUT;
          end
        end
        S_OUT: begin
          // The next keystream is requested only after this block drains.
          if (i_ct_ready) begin
            o_ct_valid <= 1'b0;
            if (blk_cnt == num_blks) begin
              state <= S_DONE;
            end else begin
              ctr_lo <= inc32(ctr_lo);
              state  <= S_CTR_REQ;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcm_ctr_scheduler.sv
// Self-checking bench for gcm_ctr_scheduler. A behavioural AES stand-in
// returns the NIST GCM TC1/TC2 values for the zero-key/zero-IV blocks and a
// fixed scrambling function for every other block. Expected ciphertext is
// queued at stimulus time and a monitor compares it as blocks leave the DUT.
module tb_gcm_ctr_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start;
  logic [95:0]  i_iv;
  logic [15:0]  i_num_blks;
  logic         o_busy, o_done, o_aes_en;
  logic [127:0] o_aes_block;
  logic         i_aes_ready, i_aes_valid;
  logic [127:0] i_aes_block;
  logic         i_pt_valid, o_pt_ready;
  logic [127:0] i_pt_data;
  logic         o_ct_valid, i_ct_ready;
  logic [127:0] o_ct_data, o_h, o_ekj0;
  logic         o_h_valid, o_ekj0_valid;

  gcm_ctr_scheduler #(.BLK_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_iv(i_iv), .i_num_blks(i_num_blks),
    .o_busy(o_busy), .o_done(o_done), .o_aes_en(o_aes_en), .o_aes_block(o_aes_block),
    .i_aes_ready(i_aes_ready), .i_aes_valid(i_aes_valid), .i_aes_block(i_aes_block),
    .i_pt_valid(i_pt_valid), .o_pt_ready(o_pt_ready), .i_pt_data(i_pt_data),
    .o_ct_valid(o_ct_valid), .i_ct_ready(i_ct_ready), .o_ct_data(o_ct_data),
    .o_h(o_h), .o_h_valid(o_h_valid), .o_ekj0(o_ekj0), .o_ekj0_valid(o_ekj0_valid)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int valid_cyc = 0;
  int ct_cnt = 0;
  bit aes_hold = 1'b0;
  int aes_lat = 10;
  logic [127:0] exp_q[$];
  logic [127:0] pt_q[$];
  logic [127:0] aes_log[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [127:0] aes_fn(input logic [127:0] b);
    case (b)
      128'h0:                                   return 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
      128'h00000000000000000000000000000001:    return 128'h58e2fccefa7e3061367f1d57a4e7455a;
      128'h00000000000000000000000000000002:    return 128'h0388dace60b6a392f328c2b971b2fe78;
      default: return {b[63:0], ~b[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, got, exp);
    end
  endtask

  // AES core stand-in: accepts a request, drops ready, returns after aes_lat cycles.
  initial begin
    logic [127:0] blk;
    i_aes_ready = 1'b0;
    i_aes_valid = 1'b0;
    i_aes_block = 128'd0;
    forever begin
      @(negedge clk);
      i_aes_ready = !aes_hold;
      #1;
      if (o_aes_en) begin
        blk = o_aes_block;
        aes_log.push_back(blk);
        @(negedge clk);
        i_aes_ready = 1'b0;
        repeat (aes_lat - 2) @(negedge clk);
        i_aes_valid = 1'b1;
        i_aes_block = aes_fn(blk);
        valid_cyc   = cyc;
        @(negedge clk);
        i_aes_valid = 1'b0;
      end
    end
  end

  // Plaintext source: offers the head of pt_q, pops after each accepted transfer.
  initial begin
    bit pend;
    pend = 1'b0;
    i_pt_valid = 1'b0;
    i_pt_data  = 128'd0;
    forever begin
      @(negedge clk);
      if (pend && pt_q.size() > 0) void'(pt_q.pop_front());
      i_pt_valid = (pt_q.size() > 0);
      i_pt_data  = (pt_q.size() > 0) ? pt_q[0] : 128'd0;
      #1;
      pend = i_pt_valid && o_pt_ready;
    end
  end

  // Monitor: counts done pulses and checks every ciphertext transfer against the queue.
  initial forever begin
    @(negedge clk);
    #2;
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (o_ct_valid && i_ct_ready) begin
      ct_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ct_unexpected actual=%h required=none", o_ct_data);
      end else begin
        chk("ct_data", o_ct_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic start_job(input logic [95:0] iv, input int n, input logic [31:0] first_lo,
                           input logic [127:0] pt_seed);
    logic [31:0]  lo;
    logic [127:0] pt;
    for (int k = 0; k < n; k++) begin
      lo = first_lo + 32'(k);
      pt = pt_seed + 128'(k);
      pt_q.push_back(pt);
      exp_q.push_back(pt ^ aes_fn({iv, lo}));
    end
    @(negedge clk);
    i_iv       = iv;
    i_num_blks = 16'(n);
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base);
    int t;
    t = 0;
    while (done_cnt == base && t < 2000) begin
      @(negedge clk);
      #3;
      t++;
    end
    checks++;
    if (done_cnt == base) begin
      failures++;
      $display("FAIL %s actual=no_done required=done", name);
    end
  endtask

  task automatic wait_log(input string name, input int n);
    int t;
    t = 0;
    while (aes_log.size() < n && t < 500) begin
      @(negedge clk);
      #3;
      t++;
    end
    checks++;
    if (aes_log.size() < n) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, aes_log.size(), n);
    end
  endtask

  initial begin
    int lb, db, cb, t;
    logic [127:0] d;
    bit stable, prdy, en_seen;
    rst_n = 1'b0; i_start = 1'b0; i_iv = 96'd0; i_num_blks = 16'd0; i_ct_ready = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    chk("reset_ctrl", {o_busy, o_done, o_aes_en, o_pt_ready, o_ct_valid, o_h_valid, o_ekj0_valid}, 128'd0);
    chk("reset_aes_block", o_aes_block, 128'd0);
    chk("reset_h_ekj0", o_h | o_ekj0, 128'd0);
    chk("reset_ct_data", o_ct_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // NIST GCM TC1/TC2 with one all-zero plaintext block.
    lb = aes_log.size(); db = done_cnt; cb = ct_cnt;
    start_job(96'd0, 1, 32'h2, 128'd0);
    #3;
    chk("start_latency_busy", o_busy, 1'b1);
    wait_done("tc1_done", db);
    chk("tc1_h", o_h, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    chk("tc1_ekj0", o_ekj0, 128'h58e2fccefa7e3061367f1d57a4e7455a);
    chk("tc1_valids", {o_h_valid, o_ekj0_valid}, 2'b11);
    repeat (5) @(negedge clk);
    #3;
    chk("tc1_aes_en_count", aes_log.size() - lb, 3);
    chk("tc1_ct_count", ct_cnt - cb, 1);
    chk("tc1_done_pulses", done_cnt - db, 1);

    // Empty message: only H and J0 are requested.
    lb = aes_log.size(); db = done_cnt; cb = ct_cnt;
    start_job(96'h0123456789abcdef01234567, 0, 32'h2, 128'd0);
    wait_done("zero_done", db);
    repeat (5) @(negedge clk);
    #3;
    chk("zero_aes_en_count", aes_log.size() - lb, 2);
    chk("zero_j0_block", aes_log[lb + 1], {96'h0123456789abcdef01234567, 32'h1});
    chk("zero_ct_count", ct_cnt - cb, 0);
    chk("zero_done_after_j0", done_cyc - valid_cyc, 1);
    chk("zero_ekj0", o_ekj0, aes_fn({96'h0123456789abcdef01234567, 32'h1}));

    // Three blocks with ciphertext back-pressure on the first one.
    lb = aes_log.size(); db = done_cnt; cb = ct_cnt;
    i_ct_ready = 1'b0;
    start_job(96'hcafebabe_deadbeef_00c0ffee, 3, 32'h2, 128'h11112222333344445555666677778888);
    t = 0;
    while (!o_ct_valid && t < 200) begin
      @(negedge clk); #3; t++;
    end
    chk("bp_ct_valid_seen", o_ct_valid, 1'b1);
    d = o_ct_data; stable = 1'b1; prdy = 1'b0; en_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      #3;
      stable  = stable && o_ct_valid && (o_ct_data == d);
      prdy    = prdy || o_pt_ready;
      en_seen = en_seen || o_aes_en;
    end
    chk("bp_ct_stable", stable, 1'b1);
    chk("bp_no_pt_ready", prdy, 1'b0);
    chk("bp_no_aes_en", en_seen, 1'b0);
    @(negedge clk);
    i_ct_ready = 1'b1;
    wait_done("bp_done", db);
    chk("bp_ct_count", ct_cnt - cb, 3);
    chk("bp_ctr_lows", {aes_log[lb + 2][31:0], aes_log[lb + 3][31:0], aes_log[lb + 4][31:0]},
        {32'h2, 32'h3, 32'h4});

    // AES core not ready while the FSM sits in CTR_REQ.
    lb = aes_log.size(); db = done_cnt; cb = ct_cnt;
    start_job(96'h5a5a5a5a_a5a5a5a5_0f0f0f0f, 1, 32'h2, 128'h9);
    wait_log("hold_j0_issued", lb + 2);
    aes_hold = 1'b1;
    t = 0;
    while (!o_ekj0_valid && t < 200) begin
      @(negedge clk); #3; t++;
    end
    en_seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      #3;
      en_seen = en_seen || o_aes_en || !o_busy;
    end
    chk("hold_no_aes_en", en_seen, 1'b0);
    chk("hold_log_size", aes_log.size() - lb, 2);
    @(negedge clk);
    aes_hold = 1'b0;
    wait_done("hold_done", db);
    chk("hold_ct_count", ct_cnt - cb, 1);

    // Counter wrap: low word forced to FFFFFFFF while J0 is in flight.
    lb = aes_log.size(); db = done_cnt;
    start_job({96{1'b1}}, 3, 32'hFFFF_FFFF, 128'h77);
    wait_log("wrap_j0_issued", lb + 2);
    @(negedge clk);
    force dut.ctr_lo = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.ctr_lo;
    wait_done("wrap_done", db);
    chk("wrap_low_words", {aes_log[lb + 2][31:0], aes_log[lb + 3][31:0], aes_log[lb + 4][31:0]},
        {32'hFFFF_FFFF, 32'h0, 32'h1});
    chk("wrap_upper_const", aes_log[lb + 2][127:32] & aes_log[lb + 3][127:32] & aes_log[lb + 4][127:32],
        {96{1'b1}});

    // Reset during the second CTR_WAIT, then a spurious late AES result.
    lb = aes_log.size(); db = done_cnt;
    start_job(96'h13579bdf_2468ace0_fedcba98, 3, 32'h2, 128'h5);
    wait_log("rst_ctr2_issued", lb + 4);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    pt_q.delete();
    #3;
    chk("rst_outputs_zero", {o_busy, o_done, o_aes_en, o_pt_ready, o_ct_valid, o_h_valid, o_ekj0_valid}, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    #3;
    chk("rst_idle_after_spurious", {o_busy, o_ct_valid, o_h_valid, o_ekj0_valid}, 128'd0);
    chk("rst_aes_block_zero", o_aes_block, 128'd0);
    chk("rst_no_done", done_cnt - db, 0);

    // Fresh two-block job with an ignored i_start during CTR_WAIT.
    lb = aes_log.size(); db = done_cnt; cb = ct_cnt;
    start_job(96'h0badf00d_11223344_55667788, 2, 32'h2, 128'h42);
    wait_log("ign_ctr1_issued", lb + 3);
    @(negedge clk);
    i_iv = 96'hffff0000ffff0000ffff0000;
    i_num_blks = 16'd5;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done("ign_done", db);
    repeat (5) @(negedge clk);
    #3;
    chk("ign_ct_count", ct_cnt - cb, 2);
    chk("ign_aes_en_count", aes_log.size() - lb, 4);
    chk("ign_iv_kept", aes_log[lb + 3][127:32], 96'h0badf00d_11223344_55667788);
    chk("ign_exp_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
